// File: rtl/regfile_write_stage.sv
// Write side of the 32x32 register file: buffers write-backs in a small FIFO,
// drains one entry per cycle into the array, and serves two forwarding read ports.
module regfile_write_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     ctrl_reset_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        ctrl_writeReg,
  input  logic [DATA_W-1:0]        data_writeReg,
  input  logic [ADDR_W-1:0]        ctrl_readRegA,
  input  logic [ADDR_W-1:0]        ctrl_readRegB,
  output logic [DATA_W-1:0]        data_readRegA,
  output logic [DATA_W-1:0]        data_readRegB,
  output logic                     commit_valid,
  output logic [ADDR_W-1:0]        commit_reg,
  output logic [$clog2(DEPTH):0]   pending_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q      [NREG];
  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              commit_valid_q, commit_valid_d;
  logic [ADDR_W-1:0] commit_reg_q, commit_reg_d;
  logic              push_s, pop_s;

  // Ready depends only on reset and occupancy, never on wr_valid.
  assign wr_ready = ctrl_reset_n & (count_q < CNT_W'(DEPTH));
  // Writes to register 0 are accepted but never enqueued.
  assign push_s   = wr_valid & wr_ready & (ctrl_writeReg != {ADDR_W{1'b0}});
  assign pop_s    = (count_q != {CNT_W{1'b0}});

  // Next-state for FIFO pointers, occupancy and the commit report.
  always_comb begin
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_reg_d   = commit_reg_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d       = rd_ptr_q + PTR_W'(1);
      commit_valid_d = 1'b1;
      commit_reg_d   = fifo_addr_q[rd_ptr_q];
    end else begin
      rd_ptr_d       = rd_ptr_q;
      commit_valid_d = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      rd_ptr_q       <= {PTR_W{1'b0}};
      wr_ptr_q       <= {PTR_W{1'b0}};
      count_q        <= {CNT_W{1'b0}};
      commit_valid_q <= 1'b0;
      commit_reg_q   <= {ADDR_W{1'b0}};
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_reg_q   <= commit_reg_d;
    end
  end

  // FIFO entry storage; pending entries are discarded on reset.
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= {ADDR_W{1'b0}};
        fifo_data_q[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      fifo_addr_q[wr_ptr_q] <= ctrl_writeReg;
      fifo_data_q[wr_ptr_q] <= data_writeReg;
    end
  end

  // Register array: the head entry is committed whenever the FIFO is non-empty.
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= {DATA_W{1'b0}};
      end
    end else if (pop_s) begin
      regs_q[fifo_addr_q[rd_ptr_q]] <= fifo_data_q[rd_ptr_q];
    end
  end

  // Scan oldest to youngest so the newest matching pending entry wins.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] val;
    logic [PTR_W-1:0]  slot;
    val = regs_q[idx];
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr_q + PTR_W'(i);
      val  = ((CNT_W'(i) < count_q) && (fifo_addr_q[slot] == idx)) ? fifo_data_q[slot] : val;
    end
    if (idx == {ADDR_W{1'b0}}) begin
      val = {DATA_W{1'b0}};
    end else begin
      val = val;
    end
    return val;
  endfunction

  assign data_readRegA = read_port(ctrl_readRegA);
  assign data_readRegB = read_port(ctrl_readRegB);

  assign commit_valid  = commit_valid_q;
  assign commit_reg    = commit_reg_q;
  assign pending_count = count_q;

endmodule

// File: tb/tb_regfile_write_stage.sv
// Directed self-checking bench for regfile_write_stage with hand-computed expectations.
module tb_regfile_write_stage;

  logic        clock;
  logic        ctrl_reset_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        commit_valid;
  logic [4:0]  commit_reg;
  logic [2:0]  pending_count;

  int n_checks = 0;
  int n_errors = 0;

  regfile_write_stage #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clock         (clock),
    .ctrl_reset_n  (ctrl_reset_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .ctrl_writeReg (ctrl_writeReg),
    .data_writeReg (data_writeReg),
    .ctrl_readRegA (ctrl_readRegA),
    .ctrl_readRegB (ctrl_readRegB),
    .data_readRegA (data_readRegA),
    .data_readRegB (data_readRegB),
    .commit_valid  (commit_valid),
    .commit_reg    (commit_reg),
    .pending_count (pending_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_wr(input logic v, input logic [4:0] r, input logic [31:0] d);
    wr_valid      = v;
    ctrl_writeReg = r;
    data_writeReg = d;
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a, input logic [4:0] b);
    ctrl_readRegA = a;
    ctrl_readRegB = b;
    #1;
  endtask

  initial begin
    ctrl_reset_n  = 1'b0;
    wr_valid      = 1'b1;
    ctrl_writeReg = 5'd3;
    data_writeReg = 32'h0000_0055;
    ctrl_readRegA = 5'd3;
    ctrl_readRegB = 5'd5;

    // 1 reset with a write request held
    tick();
    tick();
    check("rst_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_readA", data_readRegA, 32'd0);
    check("rst_readB", data_readRegB, 32'd0);
    check("rst_pending", {29'd0, pending_count}, 32'd0);
    check("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
    check("rst_commit_reg", {27'd0, commit_reg}, 32'd0);

    ctrl_reset_n = 1'b1;
    drive_wr(1'b0, 5'd0, 32'd0);
    tick();

    // 2 single write r5
    drive_wr(1'b1, 5'd5, 32'hDEAD_BEEF);
    set_rd(5'd5, 5'd5);
    check("w1_ready", {31'd0, wr_ready}, 32'd1);
    check("w1_not_fwd_same_cycle", data_readRegA, 32'd0);
    tick();
    drive_wr(1'b0, 5'd0, 32'd0);
    check("w1_fwd", data_readRegA, 32'hDEAD_BEEF);
    check("w1_pend1", {29'd0, pending_count}, 32'd1);
    check("w1_cv0", {31'd0, commit_valid}, 32'd0);
    tick();
    check("w1_cv1", {31'd0, commit_valid}, 32'd1);
    check("w1_creg", {27'd0, commit_reg}, 32'd5);
    check("w1_pend0", {29'd0, pending_count}, 32'd0);
    check("w1_array", data_readRegB, 32'hDEAD_BEEF);
    tick();
    check("w1_cv_pulse", {31'd0, commit_valid}, 32'd0);

    // 3 back-to-back writes r1..r5; one push and one pop per edge keeps one pending
    for (int k = 1; k <= 5; k++) begin
      drive_wr(1'b1, 5'(k), 32'h100 + 32'(k));
      check($sformatf("fill_ready_%0d", k), {31'd0, wr_ready}, 32'd1);
      tick();
      check($sformatf("fill_pend_%0d", k), {29'd0, pending_count}, 32'd1);
      if (k > 1) begin
        check($sformatf("fill_creg_%0d", k), {27'd0, commit_reg}, 32'(k - 1));
      end
    end
    drive_wr(1'b0, 5'd0, 32'd0);
    tick();
    check("fill_last_creg", {27'd0, commit_reg}, 32'd5);
    check("fill_drained", {29'd0, pending_count}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      set_rd(5'(k), 5'(6 - k));
      check($sformatf("fill_arrA_%0d", k), data_readRegA, 32'h100 + 32'(k));
      check($sformatf("fill_arrB_%0d", k), data_readRegB, 32'h100 + 32'(6 - k));
    end

    // 4 overwrite r7 on consecutive cycles
    set_rd(5'd0, 5'd7);
    drive_wr(1'b1, 5'd7, 32'h1);
    tick();
    drive_wr(1'b1, 5'd7, 32'h2);
    check("ow_first", data_readRegB, 32'h1);
    tick();
    drive_wr(1'b0, 5'd0, 32'd0);
    check("ow_second_fwd", data_readRegB, 32'h2);
    tick();
    check("ow_commit", data_readRegB, 32'h2);
    check("ow_creg", {27'd0, commit_reg}, 32'd7);
    tick();
    check("ow_final", data_readRegB, 32'h2);
    check("ow_pend0", {29'd0, pending_count}, 32'd0);

    // 5 write to r0 is consumed and dropped
    drive_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
    set_rd(5'd0, 5'd7);
    check("r0_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    drive_wr(1'b0, 5'd0, 32'd0);
    check("r0_pend", {29'd0, pending_count}, 32'd0);
    check("r0_cv", {31'd0, commit_valid}, 32'd0);
    check("r0_read", data_readRegA, 32'd0);
    tick();
    check("r0_cv_later", {31'd0, commit_valid}, 32'd0);
    check("r0_read_later", data_readRegA, 32'd0);

    // 6 reset with an entry still pending
    drive_wr(1'b1, 5'd9, 32'h0000_00AA);
    tick();
    set_rd(5'd9, 5'd5);
    check("mid_fwd_before_rst", data_readRegA, 32'h0000_00AA);
    check("mid_pend_before_rst", {29'd0, pending_count}, 32'd1);
    ctrl_reset_n = 1'b0;
    drive_wr(1'b0, 5'd0, 32'd0);
    tick();
    ctrl_reset_n = 1'b1;
    #1;
    check("mid_pend", {29'd0, pending_count}, 32'd0);
    check("mid_cv", {31'd0, commit_valid}, 32'd0);
    check("mid_r9", data_readRegA, 32'd0);
    check("mid_r5_cleared", data_readRegB, 32'd0);
    tick();
    check("mid_no_late_commit", {31'd0, commit_valid}, 32'd0);
    check("mid_r9_still0", data_readRegA, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
